// File: rtl/demux_pkg.sv
// Shared types for the buffered 1:2 word demultiplexer and its output FIFOs.
package demux_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        SEL_OUT0 = 1'b0,
        SEL_OUT1 = 1'b1
    } sel_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/demux_fifo.sv
// Small circular FIFO with an occupancy state machine (EMPTY/PARTIAL/FULL).
// Pushes while full and pops while empty are ignored; head reads 0 when empty.
module demux_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    import demux_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    occ_state_t        state_q;
    occ_state_t        state_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (state_q == FULL);
    assign empty   = (state_q == EMPTY);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (do_push) state_d = PARTIAL;
            end
            PARTIAL: begin
                if (do_push && !do_pop && count == CNT_LAST) begin
                    state_d = FULL;
                end else if (do_pop && !do_push && count == CNT_ONE) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (do_pop) state_d = PARTIAL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Pointer widths equal log2(DEPTH), so increments wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/demux_32_buffered.sv
// 1:2 word router with a per-output FIFO; a stalled output only blocks its own pushes.
// Optional counters (accepted pushes per output, input stall cycles) under DEMUX_STATS_EN.
module demux_32_buffered #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
`ifdef DEMUX_STATS_EN
    input  logic              out1_ready,
    output logic [15:0]       stat0_cnt,
    output logic [15:0]       stat1_cnt,
    output logic [15:0]       stall_cnt
`else
    input  logic              out1_ready
`endif
);
    import demux_pkg::*;

    sel_t sel;
    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic push0;
    logic push1;

    assign sel = sel_t'(in_sel);

    // Readiness depends only on registered occupancy, never on the consumer ready inputs.
    assign in_ready = (sel == SEL_OUT1) ? !full1 : !full0;
    assign push0    = in_valid && in_ready && (sel == SEL_OUT0);
    assign push1    = in_valid && in_ready && (sel == SEL_OUT1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;

    demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .wdata (in_data),
        .pop   (out0_ready),
        .full  (full0),
        .empty (empty0),
        .head  (out0_data)
    );

    demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .wdata (in_data),
        .pop   (out1_ready),
        .full  (full1),
        .empty (empty1),
        .head  (out1_data)
    );

`ifdef DEMUX_STATS_EN
    // Push counters wrap; the stall counter saturates so long stalls stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat0_cnt <= '0;
            stat1_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push0) stat0_cnt <= stat0_cnt + 1'b1;
            if (push1) stat1_cnt <= stat1_cnt + 1'b1;
            if (in_valid && !in_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_32_buffered.sv
// Self-checking bench for demux_32_buffered: constant vector table, queue-based
// reference model, hand sequences for backpressure, wrap-around and async reset.
module tb_demux_32_buffered;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
`ifdef DEMUX_STATS_EN
    logic [15:0] stat0_cnt;
    logic [15:0] stat1_cnt;
    logic [15:0] stall_cnt;
`endif

    demux_32_buffered #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
`ifdef DEMUX_STATS_EN
        .out1_ready (out1_ready),
        .stat0_cnt  (stat0_cnt),
        .stat1_cnt  (stat1_cnt),
        .stall_cnt  (stall_cnt)
`else
        .out1_ready (out1_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per output, head at index 0.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] rx0[$];
    logic [31:0] rx1[$];
    bit          last_acc;

    typedef struct {
        logic        valid;
        logic        sel;
        logic [31:0] data;
        logic        r0;
        logic        r1;
        logic        e_ready;
        logic        e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
    } vec_t;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [31:0] d,
                                 input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic checkOutput(input string tag);
        int sz;
        sz = in_sel ? q1.size() : q0.size();
        cmp({tag, ".in_ready"},   32'(in_ready),   32'(sz < DEPTH));
        cmp({tag, ".out0_valid"}, 32'(out0_valid), 32'(q0.size() > 0));
        cmp({tag, ".out0_data"},  out0_data,       (q0.size() > 0) ? q0[0] : 32'd0);
        cmp({tag, ".out1_valid"}, 32'(out1_valid), 32'(q1.size() > 0));
        cmp({tag, ".out1_data"},  out1_data,       (q1.size() > 0) ? q1[0] : 32'd0);
    endtask

    // Applies the rules to pre-edge state: pops from non-empty queues, push if room.
    task automatic updateModel();
        bit acc;
        acc = in_valid && ((in_sel ? q1.size() : q0.size()) < DEPTH);
        if (out0_ready && q0.size() > 0) rx0.push_back(q0.pop_front());
        if (out1_ready && q1.size() > 0) rx1.push_back(q1.pop_front());
        if (acc) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
        last_acc = acc;
    endtask

    task automatic step(input string tag);
        #1;
        checkOutput(tag);
        @(posedge clk);
        updateModel();
        #1;
    endtask

    vec_t vecs[11];

    initial begin
        bit          timed_out;
        int          sent;
        int          cyc;
        logic [31:0] prev_d1;
        bit          prev_stall;

        vecs[0]  = '{1'b1, 1'b0, 32'd34, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'd61, 1'b1, 1'b1, 1'b1, 1'b1, 32'd34, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd61};
        vecs[3]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
        vecs[4]  = '{1'b1, 1'b0, 32'd1,  1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
        vecs[5]  = '{1'b1, 1'b0, 32'd2,  1'b0, 1'b1, 1'b1, 1'b1, 32'd1,  1'b0, 32'd0};
        vecs[6]  = '{1'b1, 1'b0, 32'd9,  1'b0, 1'b1, 1'b0, 1'b1, 32'd1,  1'b0, 32'd0};
        vecs[7]  = '{1'b1, 1'b1, 32'd9,  1'b0, 1'b1, 1'b1, 1'b1, 32'd1,  1'b0, 32'd0};
        vecs[8]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 1'b1, 32'd1,  1'b1, 32'd9};
        vecs[9]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 1'b1, 32'd2,  1'b0, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        #23;
        rst_n = 1'b1;
        #1;
        cmp("reset.in_ready",   32'(in_ready),   32'd1);
        cmp("reset.out0_valid", 32'(out0_valid), 32'd0);
        cmp("reset.out0_data",  out0_data,       32'd0);
        cmp("reset.out1_valid", 32'(out1_valid), 32'd0);
        cmp("reset.out1_data",  out1_data,       32'd0);
        @(posedge clk);
        #1;

        $display("[TB] vector table: route and backpressure");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].r0, vecs[i].r1);
            #1;
            cmp($sformatf("vec%0d.in_ready", i),   32'(in_ready),   32'(vecs[i].e_ready));
            cmp($sformatf("vec%0d.out0_valid", i), 32'(out0_valid), 32'(vecs[i].e_v0));
            cmp($sformatf("vec%0d.out0_data", i),  out0_data,       vecs[i].e_d0);
            cmp($sformatf("vec%0d.out1_valid", i), 32'(out1_valid), 32'(vecs[i].e_v1));
            cmp($sformatf("vec%0d.out1_data", i),  out1_data,       vecs[i].e_d1);
            @(posedge clk);
            updateModel();
            #1;
        end

        $display("[TB] simultaneous push/pop on full FIFO 0");
        rx0.delete();
        applyStimulus(1'b1, 1'b0, 32'd1, 1'b0, 1'b0); step("sim.push1");
        applyStimulus(1'b1, 1'b0, 32'd2, 1'b0, 1'b0); step("sim.push2");
        applyStimulus(1'b1, 1'b0, 32'd3, 1'b1, 1'b0);
        #1;
        cmp("sim.full_refuse", 32'(in_ready), 32'd0);
        step("sim.popfull");
        cmp("sim.refused", 32'(last_acc), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd3, 1'b0, 1'b0);
        #1;
        cmp("sim.ready_back", 32'(in_ready), 32'd1);
        cmp("sim.head2",      out0_data,     32'd2);
        step("sim.push3");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            step("sim.drain");
        end
        cmp("sim.rx_count", 32'(rx0.size()), 32'd3);
        for (int i = 0; i < rx0.size() && i < 3; i++) begin
            cmp($sformatf("sim.rx%0d", i), rx0[i], 32'(i + 1));
        end

        $display("[TB] wrap-around with random stalls on output 1");
        rx1.delete();
        sent = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_d1 = 32'd0;
        timed_out = 1'b0;
        while ((sent < 10 || q1.size() > 0) && !timed_out) begin
            applyStimulus(sent < 10, 1'b1, 32'(100 + sent), 1'b1, 1'($urandom_range(0, 1)));
            #1;
            if (prev_stall) cmp("wrap.stable", out1_data, prev_d1);
            prev_stall = out1_valid && !out1_ready;
            prev_d1 = out1_data;
            step("wrap");
            if (last_acc) sent++;
            cyc++;
            if (cyc >= 300) timed_out = 1'b1;
        end
        if (timed_out) cmp("wrap.timeout", 32'd1, 32'd0);
        cmp("wrap.rx_count", 32'(rx1.size()), 32'd10);
        for (int i = 0; i < rx1.size() && i < 10; i++) begin
            cmp($sformatf("wrap.rx%0d", i), rx1[i], 32'(100 + i));
        end

        $display("[TB] random traffic against model");
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step("rand");
        end

        $display("[TB] async reset mid-stream");
        applyStimulus(1'b1, 1'b0, 32'd55, 1'b0, 1'b0); step("rst.fill0");
        applyStimulus(1'b1, 1'b1, 32'd66, 1'b0, 1'b0); step("rst.fill1");
        applyStimulus(1'b0, 1'b0, 32'd0,  1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("rst.out0_valid", 32'(out0_valid), 32'd0);
        cmp("rst.out0_data",  out0_data,       32'd0);
        cmp("rst.out1_valid", 32'(out1_valid), 32'd0);
        cmp("rst.out1_data",  out1_data,       32'd0);
        cmp("rst.in_ready",   32'(in_ready),   32'd1);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'd7, 1'b0, 1'b0); step("rst.push7");
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        #1;
        cmp("rst.only7_d0", out0_data,        32'd7);
        cmp("rst.only7_v1", 32'(out1_valid),  32'd0);
        step("rst.pop7");
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        #1;
        cmp("rst.after_v0", 32'(out0_valid), 32'd0);
        step("rst.idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
